// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack front end.
package ras_pkg;

   localparam int unsigned RAS_DATA  = 64;
   localparam int unsigned RAS_WAY   = 2;
   localparam int unsigned RAS_DEPTH = 8;

   // One stack entry is reserved, so usable capacity is one less than DEPTH.
   localparam int unsigned CAP   = RAS_DEPTH - 1;
   localparam int unsigned OCC_W = $clog2(RAS_DEPTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      FLUSH
   } ras_state_t;

   typedef struct packed {
      logic                hit;
      logic [RAS_DATA-1:0] addr;
   } ras_pred_t;

   // Population count of a mask, zero-extended to 32 bits by the caller.
   function automatic int unsigned cnt_bits(input logic [31:0] m);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + 32'(m[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/ras_ctrl_pair.sv
// Intra-bundle call/ret pairing: matches each ret to the nearest earlier unmatched call,
// then reports what is left over for the stack.
module ras_ctrl_pair
   import ras_pkg::*;
#(
   parameter int unsigned DATA  = RAS_DATA,
   parameter int unsigned WAY   = RAS_WAY,
   parameter int unsigned IDX_W = (WAY > 1) ? $clog2(WAY) : 1,
   parameter int unsigned CNT_W = $clog2(WAY + 1)
) (
   input  logic [WAY-1:0]            is_call,
   input  logic [WAY-1:0]            is_ret,
   input  logic [WAY-1:0][DATA-1:0]  call_addr,
   output logic [WAY-1:0]            matched,
   output logic [WAY-1:0][IDX_W-1:0] match_idx,
   output logic [WAY-1:0][IDX_W-1:0] pop_idx,
   output logic [WAY-1:0]            res_ret,
   output logic [WAY-1:0]            res_call,
   output logic [WAY-1:0][DATA-1:0]  push_addr,
   output logic [CNT_W-1:0]          ret_cnt,
   output logic [CNT_W-1:0]          push_cnt
);

   // Walk slots oldest first, keeping unmatched calls on a small LIFO.
   always_comb begin : p_pair
      logic [WAY-1:0][IDX_W-1:0] stk;
      logic [WAY-1:0]            call_used;
      int unsigned               sp;
      int unsigned               n_pop;
      int unsigned               n_push;
      stk       = '0;
      call_used = '0;
      sp        = 0;
      n_pop     = 0;
      n_push    = 0;
      matched   = '0;
      match_idx = '0;
      pop_idx   = '0;
      res_ret   = '0;
      res_call  = '0;
      push_addr = '0;
      for (int i = 0; i < WAY; i++) begin
         if (is_call[i]) begin
            stk[IDX_W'(sp)] = IDX_W'(i);
            sp = sp + 1;
         end else if (is_ret[i]) begin
            if (sp != 0) begin
               sp = sp - 1;
               matched[i]   = 1'b1;
               match_idx[i] = stk[IDX_W'(sp)];
               call_used[stk[IDX_W'(sp)]] = 1'b1;
            end else begin
               // k-th unmatched ret consumes the k-th stack read port
               res_ret[i] = 1'b1;
               pop_idx[i] = IDX_W'(n_pop);
               n_pop = n_pop + 1;
            end
         end
      end
      res_call = is_call & ~call_used;
      for (int i = 0; i < WAY; i++) begin
         if (res_call[i]) begin
            push_addr[IDX_W'(n_push)] = call_addr[i];
            n_push = n_push + 1;
         end
      end
   end

   assign ret_cnt  = CNT_W'(cnt_bits(32'(res_ret)));
   assign push_cnt = CNT_W'(cnt_bits(32'(res_call)));

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack front end: pairs calls/rets in a bundle, drives the multi-port stack,
// and registers one predicted return address per ret slot.
module ras_ctrl
   import ras_pkg::*;
#(
   parameter int unsigned DATA  = RAS_DATA,
   parameter int unsigned WAY   = RAS_WAY,
   parameter int unsigned DEPTH = RAS_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_v,
   output logic                     in_ready,
   input  logic [WAY-1:0]           is_call,
   input  logic [WAY-1:0]           is_ret,
   input  logic [WAY-1:0][DATA-1:0] call_addr,
   input  logic                     redirect_,
   output logic                     st_flush_,
   output logic [WAY-1:0]           st_push_,
   output logic [WAY-1:0][DATA-1:0] st_wd,
   output logic [WAY-1:0]           st_pop_,
   input  logic [WAY-1:0][DATA-1:0] st_rd,
   input  logic [WAY-1:0]           st_v,
   output logic                     pred_v,
   input  logic                     pred_ready,
   output logic [WAY-1:0]           pred_hit,
   output logic [WAY-1:0][DATA-1:0] pred_addr,
   output logic                     ovf
);

   localparam int unsigned Cap  = DEPTH - 1;
   localparam int unsigned OccW = $clog2(DEPTH) + 1;
   localparam int unsigned IdxW = (WAY > 1) ? $clog2(WAY) : 1;
   localparam int unsigned CntW = $clog2(WAY + 1);

   ras_state_t            state_q, state_d;
   logic [OccW-1:0]       occ_q, occ_d, occ_acc;
   logic                  ovf_q, ovf_d, clip;
   logic                  pred_v_q, pred_v_d;
   ras_pred_t [WAY-1:0]   pred_q, pred_d, slot_pred;
   logic                  accept, order_ok;

   logic [WAY-1:0]            matched, res_ret, res_call;
   logic [WAY-1:0][IdxW-1:0]  match_idx, pop_idx;
   logic [CntW-1:0]           ret_cnt, push_cnt;

   ras_ctrl_pair #(
      .DATA  (DATA),
      .WAY   (WAY),
      .IDX_W (IdxW),
      .CNT_W (CntW)
   ) u_pair (
      .is_call   (is_call),
      .is_ret    (is_ret),
      .call_addr (call_addr),
      .matched   (matched),
      .match_idx (match_idx),
      .pop_idx   (pop_idx),
      .res_ret   (res_ret),
      .res_call  (res_call),
      .push_addr (st_wd),
      .ret_cnt   (ret_cnt),
      .push_cnt  (push_cnt)
   );

   // Handshake: redirect and reset both override readiness so no bundle slips past a flush.
   always_comb begin
      in_ready = 1'b0;
      if (reset && redirect_) begin
         case (state_q)
            IDLE:    in_ready = 1'b1;
            ACTIVE:  in_ready = !pred_v_q || pred_ready;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept    = in_v && in_ready;
   assign st_flush_ = (state_q != FLUSH) || !reset;

   // Stack commands: pops first, then pushes clamped to the room left after those pops.
   always_comb begin : p_stack
      int unsigned occ_i, r, c, occ_pop, room, n_push;
      occ_i   = 32'(occ_q);
      r       = 32'(ret_cnt);
      c       = 32'(push_cnt);
      occ_pop = (occ_i > r) ? occ_i - r : 0;
      room    = Cap - occ_pop;
      n_push  = (c < room) ? c : room;
      clip    = c > room;
      occ_acc = OccW'(occ_pop + n_push);
      st_pop_  = '1;
      st_push_ = '1;
      if (accept) begin
         for (int unsigned k = 0; k < WAY; k++) begin
            st_pop_[k]  = !(k < r);
            st_push_[k] = !(k < n_push);
         end
      end
   end

   // Per-slot prediction: paired rets forward their call address, others read the stack.
   always_comb begin
      slot_pred = '0;
      for (int i = 0; i < WAY; i++) begin
         if (matched[i]) begin
            slot_pred[i].hit  = 1'b1;
            slot_pred[i].addr = RAS_DATA'(call_addr[match_idx[i]]);
         end else if (res_ret[i]) begin
            slot_pred[i].hit  = st_v[pop_idx[i]];
            slot_pred[i].addr = st_v[pop_idx[i]] ? RAS_DATA'(st_rd[pop_idx[i]]) : '0;
         end
      end
   end

   // FSM next state and prediction/occupancy/overflow next values.
   always_comb begin
      state_d  = state_q;
      occ_d    = occ_q;
      ovf_d    = ovf_q;
      pred_v_d = pred_v_q;
      pred_d   = pred_q;
      case (state_q)
         IDLE: begin
            if (!redirect_)  state_d = FLUSH;
            else if (accept) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (!redirect_)                              state_d = FLUSH;
            else if (!in_v && (!pred_v_q || pred_ready)) state_d = IDLE;
         end
         FLUSH:   state_d = redirect_ ? IDLE : FLUSH;
         default: state_d = FLUSH;
      endcase
      if (!redirect_ || state_q == FLUSH) begin
         occ_d    = '0;
         ovf_d    = 1'b0;
         pred_v_d = 1'b0;
         pred_d   = '0;
      end else if (accept) begin
         occ_d    = occ_acc;
         ovf_d    = ovf_q || clip;
         pred_v_d = 1'b1;
         pred_d   = slot_pred;
      end else if (pred_ready) begin
         pred_v_d = 1'b0;
      end
   end

   // State registers; reset lands in FLUSH so the stack is cleared on release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= FLUSH;
         occ_q    <= '0;
         ovf_q    <= 1'b0;
         pred_v_q <= 1'b0;
         pred_q   <= '0;
      end else begin
         state_q  <= state_d;
         occ_q    <= occ_d;
         ovf_q    <= ovf_d;
         pred_v_q <= pred_v_d;
         pred_q   <= pred_d;
      end
   end

   // Unpack the prediction register onto the decode-facing ports.
   always_comb begin
      for (int i = 0; i < WAY; i++) begin
         pred_hit[i]  = pred_q[i].hit;
         pred_addr[i] = DATA'(pred_q[i].addr);
      end
   end

   assign pred_v = pred_v_q;
   assign ovf    = ovf_q;

   // Residue must be rets then calls, otherwise pop-before-push would reorder the stack.
   always_comb begin
      order_ok = 1'b1;
      for (int unsigned i = 0; i < WAY; i++) begin
         for (int unsigned j = 0; j < i; j++) begin
            if (res_call[j] && res_ret[i]) order_ok = 1'b0;
         end
      end
   end

   // Flag any residue ordering violation during normal operation.
   always_ff @(posedge clk) begin
      if (reset) assert (order_ok);
   end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: expectations queued at issue time, popped by monitors.
module tb_ras_ctrl;
   import ras_pkg::*;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_v = 1'b0;
   logic             in_ready;
   logic [1:0]       is_call = '0;
   logic [1:0]       is_ret = '0;
   logic [1:0][63:0] call_addr = '0;
   logic             redirect_ = 1'b1;
   logic             st_flush_;
   logic [1:0]       st_push_;
   logic [1:0][63:0] st_wd;
   logic [1:0]       st_pop_;
   logic [1:0][63:0] st_rd = '0;
   logic [1:0]       st_v = '0;
   logic             pred_v;
   logic             pred_ready = 1'b1;
   logic [1:0]       pred_hit;
   logic [1:0][63:0] pred_addr;
   logic             ovf;

   ras_ctrl #(
      .DATA  (64),
      .WAY   (2),
      .DEPTH (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_v       (in_v),
      .in_ready   (in_ready),
      .is_call    (is_call),
      .is_ret     (is_ret),
      .call_addr  (call_addr),
      .redirect_  (redirect_),
      .st_flush_  (st_flush_),
      .st_push_   (st_push_),
      .st_wd      (st_wd),
      .st_pop_    (st_pop_),
      .st_rd      (st_rd),
      .st_v       (st_v),
      .pred_v     (pred_v),
      .pred_ready (pred_ready),
      .pred_hit   (pred_hit),
      .pred_addr  (pred_addr),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  push_;
      logic [1:0]  pop_;
      logic [63:0] wd0;
      logic [63:0] wd1;
   } cmd_t;

   typedef struct {
      logic [1:0]  hit;
      logic [63:0] a0;
      logic [63:0] a1;
   } pr_t;

   cmd_t cmd_q[$];
   pr_t  pr_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic cmd_t mk_cmd(input logic [1:0] pu, input logic [1:0] po,
                                   input logic [63:0] w0, input logic [63:0] w1);
      cmd_t e;
      e.push_ = pu; e.pop_ = po; e.wd0 = w0; e.wd1 = w1;
      return e;
   endfunction

   function automatic pr_t mk_pr(input logic [1:0] h, input logic [63:0] a0, input logic [63:0] a1);
      pr_t e;
      e.hit = h; e.a0 = a0; e.a1 = a1;
      return e;
   endfunction

   // Stack-command monitor: accepted bundles pop an expectation, other cycles must be quiet.
   always @(negedge clk) begin
      if (reset) begin
         if (in_v && in_ready) begin
            if (cmd_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL cmd_unexpected: got accept expected none (t=%0t)", $time);
            end else begin
               cmd_t e;
               e = cmd_q.pop_front();
               chk("cmd_push_", 128'(st_push_), 128'(e.push_));
               chk("cmd_pop_", 128'(st_pop_), 128'(e.pop_));
               if (!e.push_[0]) chk("cmd_wd0", 128'(st_wd[0]), 128'(e.wd0));
               if (!e.push_[1]) chk("cmd_wd1", 128'(st_wd[1]), 128'(e.wd1));
            end
         end else begin
            chk("quiet_push_", 128'(st_push_), 128'(2'b11));
            chk("quiet_pop_", 128'(st_pop_), 128'(2'b11));
         end
      end
   end

   // Prediction monitor: each transfer to decode pops one expected bundle.
   always @(negedge clk) begin
      if (reset && pred_v && pred_ready) begin
         if (pr_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL pred_unexpected: got pred_v expected none (t=%0t)", $time);
         end else begin
            pr_t e;
            e = pr_q.pop_front();
            chk("pred_hit", 128'(pred_hit), 128'(e.hit));
            chk("pred_addr0", 128'(pred_addr[0]), 128'(e.a0));
            chk("pred_addr1", 128'(pred_addr[1]), 128'(e.a1));
         end
      end
   end

   task automatic send(input logic [1:0] c, input logic [1:0] r,
                       input logic [63:0] a0, input logic [63:0] a1,
                       input logic [1:0] sv, input logic [63:0] r0, input logic [63:0] r1,
                       input cmd_t ec, input pr_t ep);
      int n;
      cmd_q.push_back(ec);
      pr_q.push_back(ep);
      is_call = c; is_ret = r;
      call_addr[0] = a0; call_addr[1] = a1;
      st_v = sv; st_rd[0] = r0; st_rd[1] = r1;
      in_v = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: got in_ready=0 expected 1 (t=%0t)", $time);
      end
      @(posedge clk);
      #1;
      in_v = 1'b0; is_call = '0; is_ret = '0; st_v = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pred_v", 128'(pred_v), 128'(0));
      chk("rst_pred_hit", 128'(pred_hit), 128'(0));
      chk("rst_pred_addr", 128'(pred_addr), 128'(0));
      chk("rst_ovf", 128'(ovf), 128'(0));
      chk("rst_push_", 128'(st_push_), 128'(2'b11));
      chk("rst_pop_", 128'(st_pop_), 128'(2'b11));
      chk("rst_flush_", 128'(st_flush_), 128'(1));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      reset = 1'b1;
      #1;
      chk("post_rst_flush_", 128'(st_flush_), 128'(0));
      chk("post_rst_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
      chk("idle_flush_", 128'(st_flush_), 128'(1));
      chk("idle_in_ready", 128'(in_ready), 128'(1));

      // single call, paired pop/push, fully paired bundle
      send(2'b01, 2'b00, 64'h100, 64'h0, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b10, 2'b11, 64'h100, 64'h0), mk_pr(2'b00, 64'h0, 64'h0));
      send(2'b10, 2'b01, 64'h0, 64'h200, 2'b01, 64'h100, 64'h0,
           mk_cmd(2'b10, 2'b10, 64'h200, 64'h0), mk_pr(2'b01, 64'h100, 64'h0));
      send(2'b01, 2'b10, 64'h300, 64'h0, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b11, 2'b11, 64'h0, 64'h0), mk_pr(2'b10, 64'h0, 64'h300));
      // fill occupancy to 6; lone slot-1 call packs into wd[0]
      send(2'b11, 2'b00, 64'h400, 64'h500, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b00, 2'b11, 64'h400, 64'h500), mk_pr(2'b00, 64'h0, 64'h0));
      send(2'b11, 2'b00, 64'h600, 64'h700, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b00, 2'b11, 64'h600, 64'h700), mk_pr(2'b00, 64'h0, 64'h0));
      send(2'b10, 2'b00, 64'h0, 64'h800, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b10, 2'b11, 64'h800, 64'h0), mk_pr(2'b00, 64'h0, 64'h0));
      chk("ovf_at_6", 128'(ovf), 128'(0));
      // overflow: only one of two calls fits
      send(2'b11, 2'b00, 64'h10, 64'h20, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b10, 2'b11, 64'h10, 64'h0), mk_pr(2'b00, 64'h0, 64'h0));
      chk("ovf_set", 128'(ovf), 128'(1));
      // full stack: pop frees the slot for the push
      send(2'b10, 2'b01, 64'h0, 64'h30, 2'b01, 64'h10, 64'h0,
           mk_cmd(2'b10, 2'b10, 64'h30, 64'h0), mk_pr(2'b01, 64'h10, 64'h0));
      // two residual rets use both read ports
      send(2'b00, 2'b11, 64'h0, 64'h0, 2'b11, 64'haaa, 64'hbbb,
           mk_cmd(2'b11, 2'b00, 64'h0, 64'h0), mk_pr(2'b11, 64'haaa, 64'hbbb));

      // back-pressure: hold the last prediction while a new bundle waits
      pred_ready = 1'b0;
      cmd_q.push_back(mk_cmd(2'b10, 2'b11, 64'hc00, 64'h0));
      pr_q.push_back(mk_pr(2'b00, 64'h0, 64'h0));
      is_call = 2'b01; call_addr[0] = 64'hc00; in_v = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 128'(in_ready), 128'(0));
         chk("stall_pred_v", 128'(pred_v), 128'(1));
         chk("stall_pred_hit", 128'(pred_hit), 128'(2'b11));
         chk("stall_addr0", 128'(pred_addr[0]), 128'(64'haaa));
         chk("stall_addr1", 128'(pred_addr[1]), 128'(64'hbbb));
      end
      @(posedge clk);
      #1;
      pred_ready = 1'b1;
      @(posedge clk);
      #1;
      in_v = 1'b0; is_call = '0;
      @(negedge clk);
      chk("no_bubble_pred_v", 128'(pred_v), 128'(1));

      // redirect while a prediction is pending; same-cycle bundle must be refused
      @(posedge clk);
      #1;
      pred_ready = 1'b0;
      send(2'b01, 2'b00, 64'hd00, 64'h0, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b10, 2'b11, 64'hd00, 64'h0), mk_pr(2'b00, 64'h0, 64'h0));
      chk("ovf_sticky", 128'(ovf), 128'(1));
      redirect_ = 1'b0;
      in_v = 1'b1; is_call = 2'b01; call_addr[0] = 64'he00;
      pr_q.delete();
      @(negedge clk);
      chk("redirect_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
      redirect_ = 1'b1; in_v = 1'b0; is_call = '0;
      chk("flush_st_flush_", 128'(st_flush_), 128'(0));
      chk("flush_pred_v", 128'(pred_v), 128'(0));
      chk("flush_ovf", 128'(ovf), 128'(0));
      chk("flush_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
      chk("after_flush_flush_", 128'(st_flush_), 128'(1));
      chk("after_flush_in_ready", 128'(in_ready), 128'(1));
      pred_ready = 1'b1;

      // ret on an empty stack, then refill from zero to prove occupancy was cleared
      send(2'b00, 2'b01, 64'h0, 64'h0, 2'b00, 64'hdead, 64'h0,
           mk_cmd(2'b11, 2'b10, 64'h0, 64'h0), mk_pr(2'b00, 64'h0, 64'h0));
      send(2'b11, 2'b00, 64'h1, 64'h2, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b00, 2'b11, 64'h1, 64'h2), mk_pr(2'b00, 64'h0, 64'h0));
      send(2'b11, 2'b00, 64'h3, 64'h4, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b00, 2'b11, 64'h3, 64'h4), mk_pr(2'b00, 64'h0, 64'h0));
      send(2'b11, 2'b00, 64'h5, 64'h6, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b00, 2'b11, 64'h5, 64'h6), mk_pr(2'b00, 64'h0, 64'h0));
      chk("refill_ovf_at_6", 128'(ovf), 128'(0));
      send(2'b11, 2'b00, 64'h7, 64'h8, 2'b00, 64'h0, 64'h0,
           mk_cmd(2'b10, 2'b11, 64'h7, 64'h0), mk_pr(2'b00, 64'h0, 64'h0));
      chk("refill_ovf_set", 128'(ovf), 128'(1));

      n = 0;
      while ((pr_q.size() != 0 || cmd_q.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("pred_q_left", 128'(pr_q.size()), 128'(0));
      chk("cmd_q_left", 128'(cmd_q.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Return-address-stack front end. Sits directly upstream of the multi-port stack.
- Takes a decoded fetch bundle of up to WAY slots, tagged call/ret, over a valid/ready handshake.
- Resolves intra-bundle call→ret pairs, then drives the stack's active-low push_/pop_ vectors with packed write data.
- Returns one registered predicted return address per ret slot to decode; handles redirect flush and overflow.

Parameters:
- DATA, 64: return-address width; equals the stack DATA.
- WAY, 2: slots per bundle; the stack is instantiated with PUSH=POP=WAY.
- DEPTH, 8: stack DEPTH (BUF_EXT disabled); usable capacity CAP=DEPTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_v  in  1  bundle valid.
- in_ready  out  1  bundle accepted when in_v&in_ready.
- is_call  in  WAY  per-slot call flag; slot 0 is oldest.
- is_ret  in  WAY  per-slot return flag; a slot never has both set.
- call_addr  in  WAY×DATA  return address pushed by each call slot.
- redirect_  in  1  active-low: flush stack and drop pending output.
- st_flush_  out  1  to stack flush_.
- st_push_  out  WAY  to stack push_.
- st_wd  out  WAY×DATA  to stack wd.
- st_pop_  out  WAY  to stack pop_.
- st_rd  in  WAY×DATA  stack rd; rd[0] is top of stack.
- st_v  in  WAY  stack v.
- pred_v  out  1  prediction bundle valid.
- pred_ready  in  1  decode accepts.
- pred_hit  out  WAY  slot has a valid predicted address.
- pred_addr  out  WAY×DATA  predicted return address per slot.
- ovf  out  1  sticky overflow flag; cleared by redirect_.

Behaviour:
- Reset values: pred_v=0, pred_hit=0, pred_addr=0, ovf=0, occ=0, state=FLUSH.
- Stack controls while reset is asserted: st_push_/st_pop_ all 1, st_flush_=1.
- FSM IDLE: in_ready=1.
  - Accepted bundle → ACTIVE.
  - redirect_=0 → FLUSH.
- FSM ACTIVE: in_ready = !pred_v | pred_ready.
  - redirect_=0 → FLUSH.
  - Output drained and no in_v → IDLE.
- FSM FLUSH: lasts exactly one cycle.
  - st_flush_=0, in_ready=0, pred_v cleared, occ cleared.
  - Then → IDLE.
  - redirect_ held low keeps the FSM in FLUSH.
- redirect_ has priority over a same-cycle handshake; that bundle is not accepted.
- Stack commands are issued only in the cycle a bundle is accepted. Otherwise all push_/pop_ bits are 1.
- Pairing, combinational, in slot order: each ret matches the nearest earlier unmatched call in the same bundle.
  - Matched ret: pred_addr = that call's call_addr, pred_hit=1.
  - Neither the matched ret nor its call touches the stack.
- After pairing, the residue is always rets then calls. This matches the stack's pop-before-push order.
- Pops: r = residual ret count.
  - st_pop_[k]=0 for k<r.
  - The k-th residual ret takes st_rd[k], with pred_hit = st_v[k].
  - Popping an empty stack gives hit=0; occ floors at 0.
- Pushes: c = residual call count, clamped to c' = min(c, CAP - max(occ-r, 0)).
  - st_wd[i] = i-th residual call address, packed from index 0.
  - st_push_[i]=0 for i<c'.
  - Newest calls beyond c' are dropped and set ovf=1.
- occ_next = max(occ-r, 0) + c'. occ is 0..CAP, width $clog2(DEPTH)+1.
- Prediction register: loaded on accept; 1-cycle latency.
  - Holds while pred_v & !pred_ready.
  - Non-ret slots: pred_hit=0, pred_addr=0.
- Simultaneous accept and drain in the same cycle: the register reloads with no bubble.
- Reset mid-operation: all state returns to reset values immediately. The first cycle after release is FLUSH, to clear the stack.

Decomposition:
- Package ras_pkg:
  - typedef ras_state_t {IDLE, ACTIVE, FLUSH}.
  - localparams CAP and OCC_W.
  - typedef for a per-slot prediction struct {hit, addr}.
- One sub-module, ras_pair: purely combinational. Produces:
  - per-slot matched-call index and matched flag;
  - residual ret/call masks;
  - packed push-address list with count.
  - The popcounts reuse cnt_bits.
- The FSM, occ counter, clamp and output register live in ras_ctrl.

Test Plan:
- Reset, then bundle {call A=0x100, none} → st_push_=2'b10, st_wd[0]=0x100; next cycle pred_v=1, pred_hit=00, occ=1.
- occ=1 holding 0x100, bundle {ret, call B=0x200} → pop_=2'b10, push_=2'b10, wd[0]=0x200; pred_addr[0]=0x100, hit=01; occ=1.
- Bundle {call C=0x300, ret} → no stack activity (push_=pop_=11); pred_addr[1]=0x300, hit=10; occ unchanged.
- occ=6 (CAP=7), bundle {call 0x10, call 0x20} → only push_[0]=0, wd[0]=0x10; ovf=1; occ=7.
- pred_v=1 with pred_ready=0 for 3 cycles → in_ready=0, outputs stable, no stack commands; pred_ready=1 with new in_v → accept and reload in the same cycle.
- redirect_=0 for 1 cycle while pred_v=1 → next edge: st_flush_=0 for one cycle, pred_v=0, occ=0, ovf=0; then a ret → pop issued, hit=0.
